uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, the successor to the fixed 8-bit, 1-clock-per-bit transmitter. Adds configurable data width, parity on/off and sense, 1 or 2 stop bits, an integer baud divider, and a valid/ready input handshake that allows back-to-back frames with no idle gap. Sits between the byte source (CPU register block or FIFO) and the serial pin, clocked by UART_clk.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 1, UART_clk cycles per serial bit; legal range 1..65535.
PARITY_EN, 1, 1 = parity bit present, 0 = no parity bit.
ODD_nEVEN, 1, parity sense: 1 = odd, 0 = even. Ignored when PARITY_EN = 0.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
UART_clk  input  1  sole clock
rst_n  input  1  asynchronous, active-low reset
tx_valid  input  1  source has a word on data_in
data_in  input  DATA_W  word to send; sent LSB first
tx_ready  output  1  block accepts a word this cycle
tx  output  1  serial line; idles high
tx_busy  output  1  frame in progress
tx_done_tick  output  1  one-cycle pulse on the final clock of the last stop bit

Behaviour:
- Single clock UART_clk. Reset is asynchronous and active-low (rst_n).
- Reset values: tx=1, tx_ready=1, tx_busy=0, tx_done_tick=0. The FSM is in IDLE and all counters are 0.
- Reset mid-frame aborts the frame immediately. The line returns high with no partial stop bit.
- Handshake: a word is accepted on a rising edge where tx_valid && tx_ready. data_in is latched into the shift register on that edge. tx_valid may drop afterwards.
- Frame order:
  - start bit (0)
  - DATA_W data bits, LSB first
  - parity bit, only if PARITY_EN
  - STOP_BITS stop bits (1)
- Every bit is held for exactly CLKS_PER_BIT clocks.
- Frame length = (1 + DATA_W + PARITY_EN + STOP_BITS) * CLKS_PER_BIT clocks.
- Latency: tx is registered. The start bit appears on tx in the cycle after the accepting edge.
- Parity value = (^data) ^ ODD_nEVEN, computed on the latched word.
- FSM states and transitions:
  - IDLE -> START on handshake.
  - START -> DATA.
  - DATA loops DATA_W times.
  - DATA -> PARITY if PARITY_EN, otherwise -> STOP.
  - PARITY -> STOP.
  - STOP loops STOP_BITS times, then -> IDLE, or -> START if a new handshake occurs on the final stop-bit clock.
- Each state advances when the baud counter reaches CLKS_PER_BIT-1; the baud counter then wraps to 0.
- Bit index counter: $clog2(DATA_W) bits. It is cleared on entry to DATA and to STOP.
- tx_ready is high in IDLE, and also on the final clock of the last stop bit. This makes back-to-back frames gapless.
- tx_done_tick is high on that same final clock, for exactly one cycle per frame.
- tx_busy = (state != IDLE).
- tx_valid asserted outside a tx_ready cycle is ignored. No word is lost, because the source must hold tx_valid until it sees tx_ready.
- CLKS_PER_BIT = 1: the baud counter is constant 0, and every state advances on every clock.

Optional Feature:
Macro UART_TX_BREAK_EN.
- When defined: adds input port tx_break (1 bit).
  - If tx_break is high while in IDLE, the FSM enters BREAK.
  - In BREAK: tx=0, tx_ready=0, tx_busy=1.
  - When tx_break drops, the FSM returns to IDLE with tx=1 on the next clock.
  - A tx_break asserted during a frame is deferred until the frame completes. tx_break has priority over tx_valid in IDLE.
- When undefined: no tx_break port and no BREAK state.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK)
  - localparams for the legal ranges of DATA_W and STOP_BITS
  - a frame-length function used by the bench
- One sub-module, uart_baud_gen:
  - parameter CLKS_PER_BIT
  - inputs clear and enable; output bit_tick on the last cycle of each bit
  - instantiated once inside uart_tx_cfg.

Test Plan:
- Default parameters, CLKS_PER_BIT=4, send 0x55 -> tx samples: start 0, data 1,0,1,0,1,0,1,0, parity 1, stop 1; frame = 44 clocks; tx_done_tick exactly once, on clock 44.
- DATA_W=7, PARITY_EN=0, STOP_BITS=2, CLKS_PER_BIT=4, send 0x41 -> 10 bits, 40 clocks; no parity bit; two high stop bits.
- Back-to-back: tx_valid held high with 0xA7 then 0x3C, CLKS_PER_BIT=4 -> the second start bit begins exactly 44 clocks after the first; no idle cycle between frames; two done ticks.
- Even parity (ODD_nEVEN=0), send 0xFF and 0x00 -> parity bit 0 for both frames.
- Send 0xAA, assert rst_n=0 at clock 10 of the frame for 2 clocks -> tx=1 and tx_ready=1 during reset, no tx_done_tick; then 0x5A sends cleanly.
- With UART_TX_BREAK_EN: assert tx_break mid-frame for 50 clocks -> the frame completes first; then tx=0 until tx_break drops; tx_ready=0 throughout the break.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, legal parameter ranges and frame-length helper
// for the configurable UART transmitter.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;
  localparam int DATA_W_MIN    = 5;
  localparam int DATA_W_MAX    = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;
  function automatic int frame_clks(int data_w, int parity_en, int stop_bits, int clks_per_bit);
    return (1 + data_w + parity_en + stop_bits) * clks_per_bit;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: counts UART_clk cycles within one serial bit and pulses bit_tick
// on the last cycle; with CLKS_PER_BIT=1 the counter stays 0 and bit_tick follows enable.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic UART_clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  logic [CW-1:0] cnt_q;
  assign bit_tick = enable && (cnt_q == CW'(CLKS_PER_BIT - 1));
  always_ff @(posedge UART_clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (clear || bit_tick) cnt_q <= '0;
    else if (enable) cnt_q <= cnt_q + 1'b1;
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with valid/ready input and gapless back-to-back frames.
// Defining UART_TX_BREAK_EN adds a tx_break input that holds the line low between frames.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 1,
  parameter int ODD_nEVEN    = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic              UART_clk,
  input  logic              rst_n,
`ifdef UART_TX_BREAK_EN
  input  logic              tx_break,
`endif
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx_ready,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done_tick
);
  localparam int BW = $clog2(DATA_W);
  state_e            state_q, state_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d, tx_q, tx_d;
  logic              bit_tick, in_frame, last_stop, accept;
  assign in_frame = state_q inside {START, DATA, PARITY, STOP};
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .UART_clk(UART_clk),
    .rst_n(rst_n),
    .clear(!in_frame),
    .enable(in_frame),
    .bit_tick(bit_tick)
  );
  assign last_stop = (state_q == STOP) && bit_tick && (bit_cnt_q == BW'(STOP_BITS - 1));
  // A pending break blocks new words, including on the final stop-bit clock.
`ifdef UART_TX_BREAK_EN
  assign tx_ready = !tx_break && ((state_q == IDLE) || last_stop);
`else
  assign tx_ready = (state_q == IDLE) || last_stop;
`endif
  assign accept       = tx_valid && tx_ready;
  assign tx           = tx_q;
  assign tx_busy      = state_q != IDLE;
  assign tx_done_tick = last_stop;
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    if (accept) begin
      shreg_d = data_in;
      par_d   = (^data_in) ^ (ODD_nEVEN != 0);
    end
    case (state_q)
`ifdef UART_TX_BREAK_EN
      IDLE:  state_d = tx_break ? BREAK : accept ? START : IDLE;
      BREAK: state_d = tx_break ? BREAK : IDLE;
`else
      IDLE:  state_d = accept ? START : IDLE;
`endif
      START: if (bit_tick) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: if (bit_tick) begin
        shreg_d = shreg_q >> 1;
        if (bit_cnt_q == BW'(DATA_W - 1)) begin
          state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          bit_cnt_d = '0;
        end else bit_cnt_d = bit_cnt_q + 1'b1;
      end
      PARITY: if (bit_tick) begin
        state_d   = STOP;
        bit_cnt_d = '0;
      end
      STOP: if (bit_tick) begin
        if (bit_cnt_q == BW'(STOP_BITS - 1)) state_d = accept ? START : IDLE;
        else bit_cnt_d = bit_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // tx is registered, so it is driven from the state being entered.
    tx_d = (state_d == START || state_d == BREAK) ? 1'b0 :
           (state_d == DATA)   ? shreg_d[0] :
           (state_d == PARITY) ? par_q : 1'b1;
  end
  always_ff @(posedge UART_clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
`timescale 1ns/1ps
// tb_uart_tx_cfg: three differently configured transmitters fed directed and random words,
// compared every cycle against a per-instance expected bit stream.
module tb_uart_tx_cfg;
  localparam int NI = 3;
  localparam int CW [NI] = '{8, 7, 8};
  localparam int CP [NI] = '{1, 0, 1};
  localparam int CO [NI] = '{1, 1, 0};
  localparam int CS [NI] = '{1, 2, 2};
  localparam int CC [NI] = '{4, 4, 1};
  logic UART_clk = 1'b0, rst_n = 1'b0, brk = 1'b0;
  logic [NI-1:0] valid = '0, rdy, txl, busy, done;
  logic [8:0] din [NI] = '{default: 9'h0};
  int checks = 0, failures = 0;
  logic [63:0] fb [NI];
  int len [NI] = '{default: 0};
  int t0 [NI] = '{default: 0};
  logic inb = 1'b0;
  int cycnt = 0;
  always #5 UART_clk = ~UART_clk;
  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_cfg #(
      .DATA_W(CW[g]), .CLKS_PER_BIT(CC[g]), .PARITY_EN(CP[g]), .ODD_nEVEN(CO[g]), .STOP_BITS(CS[g])
    ) u_dut (
      .UART_clk(UART_clk),
      .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
      .tx_break(brk && (g == 0)),
`endif
      .tx_valid(valid[g]),
      .data_in(din[g][CW[g]-1:0]),
      .tx_ready(rdy[g]),
      .tx(txl[g]),
      .tx_busy(busy[g]),
      .tx_done_tick(done[g])
    );
  end
  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask
  function automatic logic exp_ready(int i);
    return !(i == 0 && (inb || brk)) && len[i] <= 1;
  endfunction
  // Expected line levels, one entry per clock: start, data LSB first, parity, stops.
  function automatic void push(int i, logic [8:0] w);
    logic b [$];
    int ones = 0;
    b.push_back(1'b0);
    for (int j = 0; j < CW[i]; j++) begin
      b.push_back(w[j]);
      ones += int'(w[j]);
    end
    if (CP[i] != 0) b.push_back((ones % 2 == 1) ? (CO[i] == 0) : (CO[i] == 1));
    for (int s = 0; s < CS[i]; s++) b.push_back(1'b1);
    fb[i] = '1;
    len[i] = 0;
    foreach (b[k])
      for (int c = 0; c < CC[i]; c++) begin
        fb[i][len[i]] = b[k];
        len[i]++;
      end
  endfunction
  always @(posedge UART_clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) len[i] = 0;
      inb = 1'b0;
    end else begin
      cycnt++;
      for (int i = 0; i < NI; i++) begin
        automatic logic acc, idle;
        acc = valid[i] && exp_ready(i);
        if (i == 0 && inb) inb = brk;
        else begin
          idle = len[i] == 0;
          if (len[i] > 0) begin
            fb[i] = fb[i] >> 1;
            len[i]--;
          end
          if (i == 0 && idle && brk) inb = 1'b1;
          else if (acc) begin
            push(i, din[i]);
            t0[i] = cycnt;
          end
        end
      end
    end
  always @(negedge UART_clk)
    for (int i = 0; i < NI; i++) begin
      automatic logic ib;
      ib = (i == 0) && inb;
      check($sformatf("tx%0d", i), txl[i], ib ? 1'b0 : (len[i] > 0) ? fb[i][0] : 1'b1);
      check($sformatf("ready%0d", i), rdy[i], exp_ready(i));
      check($sformatf("busy%0d", i), busy[i], ib || len[i] > 0);
      check($sformatf("done%0d", i), done[i], !ib && len[i] == 1);
      if (done[i] === 1'b1)
        check($sformatf("frame_len%0d", i), cycnt - t0[i] + 1,
              uart_pkg::frame_clks(CW[i], CP[i], CS[i], CC[i]));
    end
  task automatic send(int i, logic [8:0] w);
    bit ok = 1'b0;
    valid[i] = 1'b1;
    din[i] = w;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge UART_clk);
      if (rdy[i] === 1'b1) begin
        @(posedge UART_clk);
        #1 ok = 1'b1;
      end
    end
    valid[i] = 1'b0;
    if (!ok) check($sformatf("accept%0d", i), 0, 1);
  endtask
  task automatic run(int i);
    case (i)
      0: begin
        send(0, 9'h55);
        #(10 * $urandom_range(1, 5));
        send(0, 9'hA7);
        send(0, 9'h3C);
      end
      1: send(1, 9'h41);
      default: begin
        send(2, 9'hFF);
        send(2, 9'h00);
      end
    endcase
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 2) != 0) #(10 * $urandom_range(1, 6));
      send(i, 9'($urandom));
    end
  endtask
  initial begin
    repeat (3) @(posedge UART_clk);
    #1 rst_n = 1'b1;
    fork
      run(0);
      run(1);
      run(2);
    join
    #100;
    send(0, 9'hAA);
    repeat (9) @(posedge UART_clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge UART_clk);
    #1 rst_n = 1'b1;
    send(0, 9'h5A);
    #600;
`ifdef UART_TX_BREAK_EN
    send(0, 9'h96);
    #200 brk = 1'b1;
    #500 brk = 1'b0;
    #50;
    send(0, 9'h3C);
    #600;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
